// File: rtl/cva6_hpdcache_arb_pkg.sv
// Shared definitions for the CVA6 HPDcache request arbiter: width helpers,
// memory-side TID packing and the canonical requester indices.
package cva6_hpdcache_arb_pkg;

    localparam int unsigned LOAD  = 0;
    localparam int unsigned STORE = 1;
    localparam int unsigned AMO   = 2;
    localparam int unsigned PTW   = 3;

    function automatic int unsigned calc_src_w(input int unsigned nr_req);
        return (nr_req > 1) ? $clog2(nr_req) : 1;
    endfunction

    function automatic int unsigned calc_mem_tid_w(input int unsigned nr_req,
                                                   input int unsigned tid_w);
        return calc_src_w(nr_req) + tid_w;
    endfunction

    // Memory TID layout is {src_idx, req_tid}.
    function automatic logic [31:0] pack_mem_tid(input logic [31:0]   src,
                                                 input logic [31:0]   tid,
                                                 input int unsigned   tid_w);
        return (src << tid_w) | tid;
    endfunction

    function automatic logic [31:0] unpack_src(input logic [31:0] mem_tid,
                                               input int unsigned tid_w);
        return mem_tid >> tid_w;
    endfunction

endpackage

// File: rtl/cva6_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr, wrapping modulo NrReq.
module cva6_rr_pick #(
    parameter int unsigned NrReq = 4,
    parameter int unsigned SrcW  = 2
) (
    input  logic [NrReq-1:0] req,
    input  logic [SrcW-1:0]  ptr,
    output logic             found,
    output logic [SrcW-1:0]  idx
);

    logic [SrcW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NrReq; i++) begin
            cand = SrcW'((32'(ptr) + i) % NrReq);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cva6_hpdcache_req_arbiter.sv
// Shares the HPDcache core request port among NrReq requesters: round-robin
// grant with lock-until-accept, TID source tagging, per-source credit caps.
module cva6_hpdcache_req_arbiter
    import cva6_hpdcache_arb_pkg::*;
#(
    parameter int unsigned NrReq          = 4,
    parameter int unsigned ReqTidWidth    = 3,
    parameter int unsigned PayloadWidth   = 141,
    parameter int unsigned RspDataWidth   = 64,
    parameter int unsigned MaxOutstanding = 7,
    localparam int unsigned SrcW          = calc_src_w(NrReq),
    localparam int unsigned MemTidW       = calc_mem_tid_w(NrReq, ReqTidWidth)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          drain_i,
    output logic                          drained_o,
    input  logic [NrReq-1:0]              req_valid_i,
    output logic [NrReq-1:0]              req_ready_o,
    input  logic [NrReq*PayloadWidth-1:0] req_payload_i,
    input  logic [NrReq*ReqTidWidth-1:0]  req_tid_i,
    input  logic [NrReq-1:0]              req_need_rsp_i,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic [PayloadWidth-1:0]       mem_payload_o,
    output logic [MemTidW-1:0]            mem_tid_o,
    output logic                          mem_need_rsp_o,
    input  logic                          mem_rsp_valid_i,
    input  logic [MemTidW-1:0]            mem_rsp_tid_i,
    input  logic [RspDataWidth-1:0]       mem_rsp_data_i,
    input  logic                          mem_rsp_error_i,
    output logic [NrReq-1:0]              rsp_valid_o,
    output logic [ReqTidWidth-1:0]        rsp_tid_o,
    output logic [RspDataWidth-1:0]       rsp_data_o,
    output logic                          rsp_error_o,
    output logic                          proto_err_o
);

    localparam int unsigned     CntW       = 4;
    localparam logic [CntW-1:0] CNT_MAX    = CntW'(MaxOutstanding);
    localparam logic [SrcW:0]   NR_REQ_EXT = NrReq[SrcW:0];

    logic                        lock_q;
    logic [SrcW-1:0]             lock_idx_q;
    logic [SrcW-1:0]             rr_ptr_q;
    logic [NrReq-1:0][CntW-1:0]  cnt_q, cnt_d;
    logic                        proto_err_q, proto_err_d;

    logic [PayloadWidth-1:0]     payload_arr [NrReq];
    logic [ReqTidWidth-1:0]      tid_arr [NrReq];
    logic [NrReq-1:0]            eligible;
    logic [NrReq-1:0]            cnt_inc, cnt_dec;
    logic                        pick_found;
    logic [SrcW-1:0]             pick_idx, sel_idx, rr_next;
    logic                        handshake;
    logic [SrcW-1:0]             rsp_src;
    logic                        rsp_src_ok;

    always_comb begin
        for (int k = 0; k < int'(NrReq); k++) begin
            payload_arr[k] = req_payload_i[k*PayloadWidth +: PayloadWidth];
            tid_arr[k]     = req_tid_i[k*ReqTidWidth +: ReqTidWidth];
            eligible[k]    = req_valid_i[k] && !drain_i && (cnt_q[k] < CNT_MAX);
        end
    end

    cva6_rr_pick #(
        .NrReq (NrReq),
        .SrcW  (SrcW)
    ) i_rr_pick (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A locked request bypasses eligibility so drain or a full counter cannot strand it.
    assign sel_idx        = lock_q ? lock_idx_q : pick_idx;
    assign mem_valid_o    = lock_q | pick_found;
    assign handshake      = mem_valid_o & mem_ready_i;
    assign mem_payload_o  = mem_valid_o ? payload_arr[sel_idx] : '0;
    assign mem_tid_o      = mem_valid_o
                          ? MemTidW'(pack_mem_tid(32'(sel_idx), 32'(tid_arr[sel_idx]), ReqTidWidth))
                          : '0;
    assign mem_need_rsp_o = mem_valid_o & req_need_rsp_i[sel_idx];
    assign rr_next        = (sel_idx == SrcW'(NrReq - 1)) ? '0 : sel_idx + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (handshake) begin
            req_ready_o[sel_idx] = 1'b1;
        end
    end

    assign rsp_src    = SrcW'(unpack_src(32'(mem_rsp_tid_i), ReqTidWidth));
    assign rsp_src_ok = ({1'b0, rsp_src} < NR_REQ_EXT);

    always_comb begin
        rsp_valid_o = '0;
        if (mem_rsp_valid_i && rsp_src_ok) begin
            rsp_valid_o[rsp_src] = 1'b1;
        end
    end

    assign rsp_tid_o   = mem_rsp_valid_i ? mem_rsp_tid_i[ReqTidWidth-1:0] : '0;
    assign rsp_data_o  = mem_rsp_valid_i ? mem_rsp_data_i : '0;
    assign rsp_error_o = mem_rsp_valid_i & mem_rsp_error_i;

    always_comb begin
        cnt_d       = cnt_q;
        proto_err_d = proto_err_q;
        cnt_inc     = '0;
        cnt_dec     = '0;
        if (mem_rsp_valid_i && !rsp_src_ok) begin
            proto_err_d = 1'b1;
        end
        for (int k = 0; k < int'(NrReq); k++) begin
            cnt_inc[k] = handshake && mem_need_rsp_o && (sel_idx == SrcW'(k));
            cnt_dec[k] = mem_rsp_valid_i && rsp_src_ok && (rsp_src == SrcW'(k));
            if (cnt_inc[k] && !cnt_dec[k]) begin
                cnt_d[k] = cnt_q[k] + CntW'(1);
            end else if (cnt_dec[k] && !cnt_inc[k]) begin
                // A response with no credit outstanding is a protocol error; hold at zero.
                if (cnt_q[k] == '0) begin
                    proto_err_d = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (handshake) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= rr_next;
            end else if (mem_valid_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel_idx;
            end
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign drained_o   = !lock_q && (cnt_q == '0);
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_cva6_hpdcache_req_arbiter.sv
// Scoreboard bench for cva6_hpdcache_req_arbiter: directed scenarios then
// random traffic, checked against a transaction-level arbitration model.
module tb_cva6_hpdcache_req_arbiter;

    localparam int N   = 4;
    localparam int TW  = 3;
    localparam int PW  = 141;
    localparam int DW  = 64;
    localparam int MO  = 7;
    localparam int MTW = 5;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              drain_i = 1'b0;
    logic              drained_o;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*PW-1:0]   req_payload_i;
    logic [N*TW-1:0]   req_tid_i;
    logic [N-1:0]      req_need_rsp_i;
    logic              mem_valid_o;
    logic              mem_ready_i = 1'b0;
    logic [PW-1:0]     mem_payload_o;
    logic [MTW-1:0]    mem_tid_o;
    logic              mem_need_rsp_o;
    logic              mem_rsp_valid_i = 1'b0;
    logic [MTW-1:0]    mem_rsp_tid_i = '0;
    logic [DW-1:0]     mem_rsp_data_i = '0;
    logic              mem_rsp_error_i = 1'b0;
    logic [N-1:0]      rsp_valid_o;
    logic [TW-1:0]     rsp_tid_o;
    logic [DW-1:0]     rsp_data_o;
    logic              rsp_error_o;
    logic              proto_err_o;

    cva6_hpdcache_req_arbiter dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .drain_i         (drain_i),
        .drained_o       (drained_o),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_payload_i   (req_payload_i),
        .req_tid_i       (req_tid_i),
        .req_need_rsp_i  (req_need_rsp_i),
        .mem_valid_o     (mem_valid_o),
        .mem_ready_i     (mem_ready_i),
        .mem_payload_o   (mem_payload_o),
        .mem_tid_o       (mem_tid_o),
        .mem_need_rsp_o  (mem_need_rsp_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_tid_i   (mem_rsp_tid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_error_i (mem_rsp_error_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_tid_o       (rsp_tid_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_error_o     (rsp_error_o),
        .proto_err_o     (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Requester-side state: each requester holds its request until accepted.
    logic          v [N];
    logic [PW-1:0] pay [N];
    logic [TW-1:0] tid [N];
    logic          nr [N];
    logic          reissue [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]           = v[k];
            req_need_rsp_i[k]        = nr[k];
            req_payload_i[k*PW +: PW] = pay[k];
            req_tid_i[k*TW +: TW]    = tid[k];
        end
    end

    // Reference model state
    int m_ptr, m_lock, m_lidx, m_perr;
    int m_cnt [N];

    typedef struct {
        logic          mv;
        logic [N-1:0]  rdy;
        logic [MTW-1:0] mtid;
        logic          nrsp;
        logic [PW-1:0] pay;
        logic [N-1:0]  rv;
        logic [TW-1:0] rtid;
        logic [DW-1:0] rdata;
        logic          rerr;
        logic          drained;
        logic          perr;
    } exp_t;

    exp_t exp_q [$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant", {mem_valid_o, req_ready_o}, {e.mv, e.rdy});
            if (e.mv) begin
                chk("mem_tid", mem_tid_o, e.mtid);
                chk("mem_need_rsp", mem_need_rsp_o, e.nrsp);
                chk("mem_payload", mem_payload_o, e.pay);
            end
            chk("rsp_route", rsp_valid_o, e.rv);
            if (e.rv != '0) begin
                chk("rsp_fields", {rsp_tid_o, rsp_data_o, rsp_error_o}, {e.rtid, e.rdata, e.rerr});
            end
            chk("status", {drained_o, proto_err_o}, {e.drained, e.perr});
        end
    end

    task automatic load(input int k, input logic need);
        v[k]   = 1'b1;
        nr[k]  = need;
        tid[k] = TW'($urandom_range(0, 7));
        for (int b = 0; b < PW; b++) pay[k][b] = 1'($urandom_range(0, 1));
    endtask

    // One clock: drive inputs, predict outputs, advance the model.
    task automatic cycle(input logic rdy, input logic rv, input int src, input logic drn);
        exp_t e;
        int sel, sum;
        logic mv, hs, inc, dec;
        logic [TW-1:0] rtid;
        logic [DW-1:0] rdata;
        logic rerr;
        rtid  = TW'($urandom_range(0, 7));
        rdata = {$urandom, $urandom};
        rerr  = 1'($urandom_range(0, 1));
        mem_ready_i     = rdy;
        drain_i         = drn;
        mem_rsp_valid_i = rv;
        mem_rsp_tid_i   = rv ? MTW'(src * 8 + int'(rtid)) : '0;
        mem_rsp_data_i  = rdata;
        mem_rsp_error_i = rerr;
        mv = 1'b0;
        sel = 0;
        if (m_lock != 0) begin
            mv  = 1'b1;
            sel = m_lidx;
        end else begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (!mv && v[j] && !drn && m_cnt[j] < MO) begin
                    mv  = 1'b1;
                    sel = j;
                end
            end
        end
        hs = mv && rdy;
        sum = 0;
        for (int k = 0; k < N; k++) sum += m_cnt[k];
        e.mv      = mv;
        e.rdy     = hs ? N'(1 << sel) : '0;
        e.mtid    = MTW'(sel * 8 + int'(tid[sel]));
        e.nrsp    = nr[sel];
        e.pay     = pay[sel];
        e.rv      = rv ? N'(1 << src) : '0;
        e.rtid    = rtid;
        e.rdata   = rdata;
        e.rerr    = rerr;
        e.drained = (m_lock == 0) && (sum == 0);
        e.perr    = (m_perr != 0);
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        if (hs) begin
            m_lock = 0;
            m_ptr  = (sel + 1) % N;
        end else if (mv) begin
            m_lock = 1;
            m_lidx = sel;
        end
        for (int k = 0; k < N; k++) begin
            inc = hs && nr[sel] && (sel == k);
            dec = rv && (src == k);
            if (inc && !dec) m_cnt[k]++;
            else if (dec && !inc) begin
                if (m_cnt[k] == 0) m_perr = 1;
                else m_cnt[k]--;
            end
        end
        if (hs) begin
            if (reissue[sel]) load(sel, nr[sel]);
            else v[sel] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        for (int k = 0; k < N; k++) begin
            v[k] = 1'b0;
            reissue[k] = 1'b0;
        end
        mem_ready_i     = 1'b0;
        mem_rsp_valid_i = 1'b0;
        drain_i         = 1'b0;
        #1;
        chk("reset_out", {mem_valid_o, req_ready_o, rsp_valid_o, drained_o, proto_err_o},
            {1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0});
        m_ptr = 0;
        m_lock = 0;
        m_lidx = 0;
        m_perr = 0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            v[k] = 1'b0;
            pay[k] = '0;
            tid[k] = '0;
            nr[k] = 1'b0;
            reissue[k] = 1'b0;
        end
        do_reset();

        // All four valid with cache ready: grants rotate 0,1,2,3
        for (int k = 0; k < N; k++) load(k, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 0, 1'b0);

        // Lock on req1 while req0 appears; then wrap to req0
        load(1, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);
        load(0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);

        // Outstanding cap on req0; req2 still served; one response frees a credit
        reissue[0] = 1'b1;
        load(0, 1'b1);
        repeat (7) cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);
        load(2, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);
        reissue[0] = 1'b0;

        // Simultaneous grant and response on req0 at cnt=3, then stray response to req3
        repeat (4) cycle(1'b0, 1'b1, 0, 1'b0);
        cycle(1'b1, 1'b1, 0, 1'b0);
        cycle(1'b1, 1'b1, 3, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);

        // Drain with a locked request and credits outstanding
        load(1, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b0);
        load(2, 1'b0);
        load(3, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 0, 1'b1);
        for (int k = 0; k < N; k++) begin
            while (m_cnt[k] > 0) cycle(1'b1, 1'b1, k, 1'b1);
        end
        repeat (2) cycle(1'b1, 1'b0, 0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 0, 1'b0);

        // Reset with lock and counters live; stray response afterwards
        load(0, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b0);
        load(1, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);
        do_reset();
        for (int k = 0; k < N; k++) load(k, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 0, 1'b0);
        do_reset();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            int src;
            logic rv;
            for (int k = 0; k < N; k++) begin
                if (!v[k] && $urandom_range(0, 9) < 3) load(k, 1'($urandom_range(0, 1)));
            end
            src = $urandom_range(0, N - 1);
            rv  = (m_cnt[src] > 0) && ($urandom_range(0, 1) == 1);
            cycle(1'($urandom_range(0, 9) < 7), rv, src, 1'(((c / 100) % 4) == 3));
        end

        // Final drain to quiescence
        for (int c = 0; c < 300; c++) begin
            int src;
            src = $urandom_range(0, N - 1);
            cycle(1'b1, m_cnt[src] > 0, src, 1'b1);
        end
        repeat (2) cycle(1'b1, 1'b0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
